mesh_traffic_gen: RTL and testbench

//  Synthetic packet injector for one mesh node; sits directly downstream of the 8-bit lfsr.

---
 rtl/mesh_traffic_gen.sv | 161 ++++++++++++++++
 tb/tb_mesh_traffic_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_traffic_gen.sv
// Synthetic wormhole-packet injector for one mesh node, driven by an external LFSR byte.
// Head appears one cycle after the inject decision; flits hold stable while flit_ready is low.
module mesh_traffic_gen #(
   parameter int COORD_W    = 2,
   parameter int MY_X       = 0,
   parameter int MY_Y       = 0,
   parameter int FLIT_W     = 32,
   parameter int PKT_LEN    = 4,
   parameter int INJ_THRESH = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rnd_in,
   input  logic              enable,
   output logic [FLIT_W-1:0] flit_out,
   output logic              flit_valid,
   input  logic              flit_ready,
   output logic              busy,
   output logic [15:0]       pkt_count
);

   localparam logic [8:0]         THR      = 9'(INJ_THRESH);
   localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
   localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);
   localparam logic [7:0]         LAST_IDX = 8'(PKT_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEAD,
      S_BODY,
      S_TAIL
   } state_t;

   state_t              state_q, state_d;
   logic [FLIT_W-1:0]   flit_q, flit_d;
   logic                vld_q, vld_d;
   logic                busy_q, busy_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [7:0]          seq_q, seq_d;
   logic [7:0]          idx_q, idx_d;

   logic                xfer;
   logic                inject;
   logic [COORD_W-1:0]  dx_raw, dy_raw, dx_n;
   logic [7:0]          idx_nxt;

   function automatic logic [FLIT_W-1:0] mk_head(input logic [COORD_W-1:0] dx,
                                                 input logic [COORD_W-1:0] dy,
                                                 input logic [7:0]         seq);
      logic [FLIT_W-1:0] f;
      f                  = '0;
      f[FLIT_W-1 -: 2]   = 2'b01;
      f[8 +: 4*COORD_W]  = {dy, dx, MY_Y_C, MY_X_C};
      f[7:0]             = seq;
      return f;
   endfunction

   function automatic logic [FLIT_W-1:0] mk_data(input logic [1:0] ftype,
                                                 input logic [7:0] seq,
                                                 input logic [7:0] idx);
      logic [FLIT_W-1:0] f;
      f                = '0;
      f[FLIT_W-1 -: 2] = ftype;
      f[15:8]          = seq;
      f[7:0]           = idx;
      return f;
   endfunction

   assign xfer    = vld_q && flit_ready;
   assign inject  = enable && ({1'b0, rnd_in} < THR);
   assign dx_raw  = rnd_in[COORD_W-1:0];
   assign dy_raw  = rnd_in[2*COORD_W-1:COORD_W];
   // A packet to ourselves is redirected to the X neighbour (with wrap).
   assign dx_n    = (dx_raw == MY_X_C && dy_raw == MY_Y_C) ? dx_raw + 1'b1 : dx_raw;
   assign idx_nxt = idx_q + 8'd1;

   always_comb begin
      state_d = state_q;
      flit_d  = flit_q;
      vld_d   = vld_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      seq_d   = seq_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (inject) begin
               flit_d  = mk_head(dx_n, dy_raw, seq_q);
               vld_d   = 1'b1;
               busy_d  = 1'b1;
               idx_d   = 8'd0;
               state_d = S_HEAD;
            end
         end
         S_HEAD: begin
            if (xfer) begin
               idx_d = 8'd1;
               if (PKT_LEN > 2) begin
                  flit_d  = mk_data(2'b00, seq_q, 8'd1);
                  state_d = S_BODY;
               end else begin
                  flit_d  = mk_data(2'b10, seq_q, 8'd1);
                  state_d = S_TAIL;
               end
            end
         end
         S_BODY: begin
            if (xfer) begin
               idx_d = idx_nxt;
               if (idx_nxt == LAST_IDX) begin
                  flit_d  = mk_data(2'b10, seq_q, idx_nxt);
                  state_d = S_TAIL;
               end else begin
                  flit_d  = mk_data(2'b00, seq_q, idx_nxt);
               end
            end
         end
         S_TAIL: begin
            if (xfer) begin
               seq_d   = seq_q + 8'd1;
               cnt_d   = cnt_q + 16'd1;
               vld_d   = 1'b0;
               busy_d  = 1'b0;
               idx_d   = 8'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         flit_q  <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= 16'd0;
         seq_q   <= 8'd0;
         idx_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         flit_q  <= flit_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         idx_q   <= idx_d;
      end
   end

   assign flit_out   = flit_q;
   assign flit_valid = vld_q;
   assign busy       = busy_q;
   assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_mesh_traffic_gen.sv
// Scoreboard bench: main node (3,1) with threshold 128, plus always-inject and never-inject nodes.
module tb_mesh_traffic_gen;

   logic        clk;
   logic        rst;
   logic [7:0]  rnd_in;
   logic [7:0]  rnd_all;
   logic        enable;
   logic        flit_ready;

   logic [31:0] f_dat;
   logic        f_vld, busy_m;
   logic [15:0] cnt_m;
   logic [31:0] ff_dat;
   logic        ff_vld, ff_busy;
   logic [15:0] ff_cnt;
   logic [31:0] zf_dat;
   logic        zf_vld, zf_busy;
   logic [15:0] zf_cnt;

   int          total = 0;
   int          bad   = 0;
   int          ready_mode = 0;
   logic [7:0]  seq_m = 8'd0;
   logic [15:0] exp_cnt = 16'd0;
   logic [31:0] q[$];
   logic        zero_seen;

   mesh_traffic_gen #(.COORD_W(2), .MY_X(3), .MY_Y(1), .FLIT_W(32), .PKT_LEN(4), .INJ_THRESH(128)) u_dut (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .enable(enable),
      .flit_out(f_dat), .flit_valid(f_vld), .flit_ready(flit_ready),
      .busy(busy_m), .pkt_count(cnt_m));

   mesh_traffic_gen #(.COORD_W(2), .MY_X(0), .MY_Y(0), .FLIT_W(32), .PKT_LEN(4), .INJ_THRESH(256)) u_full (
      .clk(clk), .rst(rst), .rnd_in(rnd_all), .enable(1'b1),
      .flit_out(ff_dat), .flit_valid(ff_vld), .flit_ready(1'b1),
      .busy(ff_busy), .pkt_count(ff_cnt));

   mesh_traffic_gen #(.COORD_W(2), .MY_X(0), .MY_Y(0), .FLIT_W(32), .PKT_LEN(4), .INJ_THRESH(0)) u_zero (
      .clk(clk), .rst(rst), .rnd_in(rnd_all), .enable(1'b1),
      .flit_out(zf_dat), .flit_valid(zf_vld), .flit_ready(1'b1),
      .busy(zf_busy), .pkt_count(zf_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] hd(input logic [7:0] dest, input logic [7:0] seq);
      return {2'b01, 14'd0, dest, seq};
   endfunction

   function automatic logic [31:0] dt(input logic [1:0] ty, input logic [7:0] seq, input logic [7:0] idx);
      return {ty, 14'd0, seq, idx};
   endfunction

   task automatic push_pkt(input logic [7:0] dest);
      q.push_back(hd(dest, seq_m));
      q.push_back(dt(2'b00, seq_m, 8'd1));
      q.push_back(dt(2'b00, seq_m, 8'd2));
      q.push_back(dt(2'b10, seq_m, 8'd3));
   endtask

   task automatic wait_busy(input logic want, input int lim, input string nm);
      int n = 0;
      while (busy_m !== want && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      check(nm, {31'd0, busy_m}, {31'd0, want});
   endtask

   task automatic finish_pkt();
      wait_busy(1'b0, 300, "pkt_done");
      seq_m   = seq_m + 8'd1;
      exp_cnt = exp_cnt + 16'd1;
      check("pkt_count", {16'd0, cnt_m}, {16'd0, exp_cnt});
      check("drained", q.size(), 0);
   endtask

   task automatic send_pkt(input logic [7:0] rnd, input logic [7:0] dest, input bit stall);
      wait_busy(1'b0, 300, "idle_before");
      push_pkt(dest);
      if (stall) ready_mode = 2;
      rnd_in = rnd;
      @(posedge clk); #1;
      rnd_in = 8'hFF;
      if (stall) begin
         for (int i = 0; i < 5; i++) begin
            check("stall_vld", {31'd0, f_vld}, 32'd1);
            check("stall_head", f_dat, hd(dest, seq_m));
            @(posedge clk); #1;
         end
         ready_mode = 1;
      end
      finish_pkt();
      ready_mode = 0;
   endtask

   // Ready driver runs after the stimulus update of each cycle.
   initial begin
      flit_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         case (ready_mode)
            0:       flit_ready = 1'b1;
            1:       flit_ready = 1'($urandom_range(0, 1));
            default: flit_ready = 1'b0;
         endcase
      end
   end

   // Monitor: every presented flit must match the queue head; pop on handshake.
   always @(negedge clk) begin
      if (!rst && f_vld) begin
         if (q.size() == 0) begin
            check("unexpected_flit", f_dat, 32'hxxxxxxxx);
         end else begin
            check("flit", f_dat, q[0]);
            if (flit_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  ph;
      logic [7:0]  pseq;
      logic        ev;
      logic [1:0]  ety;
      logic [7:0]  aseq;

      rst = 1'b1; enable = 1'b1; rnd_in = 8'hFF; rnd_all = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vld",  {31'd0, f_vld}, 32'd0);
      check("rst_busy", {31'd0, busy_m}, 32'd0);
      check("rst_cnt",  {16'd0, cnt_m}, 32'd0);
      check("rst_flit", f_dat, 32'd0);

      // Always-inject node: head/body/body/tail/idle, period 5; never-inject node stays silent.
      rst = 1'b0;
      zero_seen = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge clk); #1;
         rnd_all = 8'($urandom);
         ph   = 3'((k - 1) % 5);
         pseq = 8'((k - 1) / 5);
         ev   = (ph != 3'd4);
         ety  = (ph == 3'd0) ? 2'b01 : (ph == 3'd3) ? 2'b10 : 2'b00;
         aseq = (ph == 3'd0) ? ff_dat[7:0] : ff_dat[15:8];
         check("full_pattern",
               {21'd0, ff_vld, ff_vld ? ff_dat[31:30] : 2'b00, ff_vld ? aseq : 8'd0},
               {21'd0, ev, ev ? ety : 2'b00, ev ? pseq : 8'd0});
         zero_seen = zero_seen | zf_vld;
      end
      check("full_count", {16'd0, ff_cnt}, 32'd200);
      check("zero_vld",   {31'd0, zero_seen}, 32'd0);
      check("zero_count", {16'd0, zf_cnt}, 32'd0);

      // Directed destinations for node (3,1).
      send_pkt(8'h07, 8'h47, 1'b0);
      send_pkt(8'h06, 8'h67, 1'b0);
      send_pkt(8'h7F, 8'hF7, 1'b0);

      // Threshold boundary: 128 must not inject.
      rnd_in = 8'h80;
      repeat (4) @(posedge clk);
      #1;
      rnd_in = 8'hFF;
      check("thr_no_inject", {31'd0, busy_m}, 32'd0);

      send_pkt(8'h00, 8'h07, 1'b1);

      // Enable dropped right after head handshake.
      wait_busy(1'b0, 300, "idle_before_en");
      push_pkt(8'h67);
      rnd_in = 8'h06;
      @(posedge clk); #1;
      rnd_in = 8'hFF;
      @(posedge clk); #1;
      enable = 1'b0;
      finish_pkt();
      rnd_in = 8'h00;
      zero_seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         zero_seen = zero_seen | f_vld;
      end
      check("en_off_quiet", {31'd0, zero_seen}, 32'd0);
      enable = 1'b1;
      rnd_in = 8'hFF;

      // Reset mid-packet while stalled.
      wait_busy(1'b0, 300, "idle_before_rst");
      q.push_back(hd(8'h07, seq_m));
      ready_mode = 2;
      rnd_in = 8'h00;
      @(posedge clk); #1;
      rnd_in = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      check("stalled_vld", {31'd0, f_vld}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_vld",  {31'd0, f_vld}, 32'd0);
      check("mid_rst_busy", {31'd0, busy_m}, 32'd0);
      check("mid_rst_cnt",  {16'd0, cnt_m}, 32'd0);
      check("mid_rst_flit", f_dat, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      q.delete();
      seq_m = 8'd0;
      exp_cnt = 16'd0;
      ready_mode = 0;
      rst = 1'b0;
      send_pkt(8'h07, 8'h47, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
